// File: rtl/sram_ctrl_pkg.sv
// Shared constants for the banked single-port SRAM array, its requesters and the bank arbiter.
// Also holds the packed-bus slice helper used by every block on the bank buses.
package sram_ctrl_pkg;

  localparam int SRAM_NUM_BANK    = 4;
  localparam int SRAM_DATA_W      = 8;
  localparam int SRAM_ADDR_W      = 10;
  localparam int SRAM_RD_MAX_WAIT = 3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } grant_e;

  // LSB of bank `bank` on a bus packed bank 0 at LSB, `width` bits per bank.
  function automatic int bank_lsb(input int bank, input int width);
    return bank * width;
  endfunction

endpackage

// File: rtl/sram_bank_arb_lane.sv
// Single-bank arbitration lane: write-priority grant with bounded read starvation,
// plus the one-cycle read-response valid flop.
module sram_bank_arb_lane
  import sram_ctrl_pkg::*;
#(
  parameter int RD_MAX_WAIT = SRAM_RD_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_valid,
  input  logic rd_valid,
  output logic wr_grant,
  output logic rd_grant,
  output logic rsp_valid
);

  localparam int               CNT_W   = $clog2(RD_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_MAX_WAIT);

  grant_e           grant;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             rd_en_p1;

  always_comb begin
    grant        = GNT_NONE;
    wait_cnt_nxt = wait_cnt;
    if (!rst) begin
      if (wr_valid && rd_valid) begin
        grant = (wait_cnt == CNT_MAX) ? GNT_RD : GNT_WR;
      end else if (wr_valid) begin
        grant = GNT_WR;
      end else if (rd_valid) begin
        grant = GNT_RD;
      end
    end
    // A write grant while a read is pending counts as one lost cycle for that read.
    if (!rd_valid || grant == GNT_RD) begin
      wait_cnt_nxt = '0;
    end else if (grant == GNT_WR && wait_cnt != CNT_MAX) begin
      wait_cnt_nxt = wait_cnt + 1'b1;
    end
  end

  assign wr_grant = (grant == GNT_WR);
  assign rd_grant = (grant == GNT_RD);

  // p0 -> p1: array samples the read address; its data returns next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      rd_en_p1 <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      rd_en_p1 <= rd_grant;
    end
  end

  // Masking with rst drops a response whose read was granted just before reset.
  assign rsp_valid = rd_en_p1 & ~rst;

endmodule

// File: rtl/sram_bank_arbiter.sv
// Per-bank read/write arbiter between requesters and the banked single-port SRAM array.
// Lanes are independent; this level only slices the packed buses and steers addr/data.
module sram_bank_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_BANK             = SRAM_NUM_BANK,
  parameter int SRAM_BANK_DATA_WIDTH = SRAM_DATA_W,
  parameter int SRAM_BANK_ADDR_WIDTH = SRAM_ADDR_W,
  parameter int RD_MAX_WAIT          = SRAM_RD_MAX_WAIT
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_BANK-1:0]                      i_wr_valid,
  output logic [NUM_BANK-1:0]                      o_wr_ready,
  input  logic [NUM_BANK*SRAM_BANK_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [NUM_BANK*SRAM_BANK_DATA_WIDTH-1:0] i_wr_data,
  input  logic [NUM_BANK-1:0]                      i_rd_valid,
  output logic [NUM_BANK-1:0]                      o_rd_ready,
  input  logic [NUM_BANK*SRAM_BANK_ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NUM_BANK-1:0]                      o_rsp_valid,
  output logic [NUM_BANK*SRAM_BANK_DATA_WIDTH-1:0] o_rsp_data,
  output logic [NUM_BANK-1:0]                      o_sram_a_wr_en,
  output logic [NUM_BANK*SRAM_BANK_ADDR_WIDTH-1:0] o_sram_a_wr_addr,
  output logic [NUM_BANK*SRAM_BANK_DATA_WIDTH-1:0] o_sram_a_wr_data,
  output logic [NUM_BANK-1:0]                      o_sram_b_rd_en,
  output logic [NUM_BANK*SRAM_BANK_ADDR_WIDTH-1:0] o_sram_b_rd_addr,
  input  logic [NUM_BANK*SRAM_BANK_DATA_WIDTH-1:0] i_sram_b_rd_data
);

  localparam int DW = SRAM_BANK_DATA_WIDTH;
  localparam int AW = SRAM_BANK_ADDR_WIDTH;

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_lane
    localparam int AL = bank_lsb(b, AW);
    localparam int DL = bank_lsb(b, DW);

    logic wr_grant;
    logic rd_grant;

    sram_bank_arb_lane #(
      .RD_MAX_WAIT (RD_MAX_WAIT)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (i_wr_valid[b]),
      .rd_valid  (i_rd_valid[b]),
      .wr_grant  (wr_grant),
      .rd_grant  (rd_grant),
      .rsp_valid (o_rsp_valid[b])
    );

    assign o_wr_ready[b]     = wr_grant;
    assign o_rd_ready[b]     = rd_grant;
    assign o_sram_a_wr_en[b] = wr_grant;
    assign o_sram_b_rd_en[b] = rd_grant;

    // Ungranted lanes drive zeros so the array buses stay quiet.
    assign o_sram_a_wr_addr[AL +: AW] = wr_grant ? i_wr_addr[AL +: AW] : {AW{1'b0}};
    assign o_sram_a_wr_data[DL +: DW] = wr_grant ? i_wr_data[DL +: DW] : {DW{1'b0}};
    assign o_sram_b_rd_addr[AL +: AW] = rd_grant ? i_rd_addr[AL +: AW] : {AW{1'b0}};
  end

  assign o_rsp_data = i_sram_b_rd_data;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Bench for sram_bank_arbiter: behavioural SRAM array, per-cycle model compare and directed vectors.
module tb_sram_bank_arbiter;

  localparam int NB = 4;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int MW = 3;

  logic              clk;
  logic              rst;
  logic [NB-1:0]     i_wr_valid, o_wr_ready, i_rd_valid, o_rd_ready, o_rsp_valid;
  logic [NB*AW-1:0]  i_wr_addr, i_rd_addr, o_sram_a_wr_addr, o_sram_b_rd_addr;
  logic [NB*DW-1:0]  i_wr_data, o_rsp_data, o_sram_a_wr_data, i_sram_b_rd_data;
  logic [NB-1:0]     o_sram_a_wr_en, o_sram_b_rd_en;

  int n_checks = 0;
  int n_err    = 0;

  sram_bank_arbiter #(
    .NUM_BANK(NB), .SRAM_BANK_DATA_WIDTH(DW), .SRAM_BANK_ADDR_WIDTH(AW), .RD_MAX_WAIT(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready), .i_rd_addr(i_rd_addr),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_sram_a_wr_en(o_sram_a_wr_en), .o_sram_a_wr_addr(o_sram_a_wr_addr), .o_sram_a_wr_data(o_sram_a_wr_data),
    .o_sram_b_rd_en(o_sram_b_rd_en), .o_sram_b_rd_addr(o_sram_b_rd_addr), .i_sram_b_rd_data(i_sram_b_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural single-port array: write or read per bank per cycle, read data one cycle later
  logic [DW-1:0] sram_mem [NB][1<<AW];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (o_sram_a_wr_en[b]) sram_mem[b][o_sram_a_wr_addr[b*AW +: AW]] <= o_sram_a_wr_data[b*DW +: DW];
      if (o_sram_b_rd_en[b]) i_sram_b_rd_data[b*DW +: DW] <= sram_mem[b][o_sram_b_rd_addr[b*AW +: AW]];
    end
  end

  // Reference model: memory contents by grant order, lost-cycle count of the pending read,
  // and the response owed next cycle.
  logic [DW-1:0] ref_mem [NB][1<<AW];
  int            lost   [NB];
  int            starve [NB];
  bit            pend   [NB];
  logic [DW-1:0] pend_d [NB];
  logic          m_wv, m_rv, m_ew, m_er;
  logic [AW-1:0] m_wa, m_ra;
  logic [DW-1:0] m_wd;
  logic [63:0]   exp_v, act_v;

  always @(negedge clk) begin
    for (int b = 0; b < NB; b++) begin
      m_wv = i_wr_valid[b];
      m_rv = i_rd_valid[b];
      m_wa = i_wr_addr[b*AW +: AW];
      m_ra = i_rd_addr[b*AW +: AW];
      m_wd = i_wr_data[b*DW +: DW];
      m_er = !rst && m_rv && (!m_wv || lost[b] >= MW);
      m_ew = !rst && m_wv && !m_er;
      exp_v = 64'({m_ew, m_er, m_ew, m_er,
                   (m_ew ? m_wa : {AW{1'b0}}), (m_ew ? m_wd : {DW{1'b0}}),
                   (m_er ? m_ra : {AW{1'b0}}), (!rst && pend[b])});
      act_v = 64'({o_wr_ready[b], o_rd_ready[b], o_sram_a_wr_en[b], o_sram_b_rd_en[b],
                   o_sram_a_wr_addr[b*AW +: AW], o_sram_a_wr_data[b*DW +: DW],
                   o_sram_b_rd_addr[b*AW +: AW], o_rsp_valid[b]});
      chk($sformatf("lane%0d", b), act_v, exp_v);
      if (!rst && pend[b]) chk($sformatf("rsp_data%0d", b), 64'(o_rsp_data[b*DW +: DW]), 64'(pend_d[b]));
      chk($sformatf("dual_en%0d", b), 64'(o_sram_a_wr_en[b] & o_sram_b_rd_en[b]), 64'(0));
      if (!rst && m_rv && !o_rd_ready[b]) starve[b]++;
      else starve[b] = 0;
      chk($sformatf("rd_wait%0d", b), 64'(starve[b] > MW), 64'(0));
      pend[b]   = m_er;
      pend_d[b] = ref_mem[b][m_ra];
      if (m_ew) ref_mem[b][m_wa] = m_wd;
      lost[b] = (m_wv && m_rv && m_ew) ? lost[b] + 1 : 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int b, input logic v, input int a, input int d);
    i_wr_valid[b]        = v;
    i_wr_addr[b*AW +: AW] = AW'(a);
    i_wr_data[b*DW +: DW] = DW'(d);
  endtask

  task automatic set_rd(input int b, input logic v, input int a);
    i_rd_valid[b]        = v;
    i_rd_addr[b*AW +: AW] = AW'(a);
  endtask

  task automatic clear_all();
    i_wr_valid = '0; i_rd_valid = '0;
    i_wr_addr  = '0; i_rd_addr  = '0; i_wr_data = '0;
  endtask

  logic [NB-1:0] wg, rg;
  logic          rd_keep, wr_keep, nv;
  int            a;

  initial begin
    for (int b = 0; b < NB; b++) begin
      lost[b] = 0; starve[b] = 0; pend[b] = 0; pend_d[b] = '0;
      for (int i = 0; i < (1 << AW); i++) begin
        sram_mem[b][i] = '0;
        ref_mem[b][i]  = '0;
      end
    end
    i_sram_b_rd_data = '0;

    // Reset held 3 cycles with every request asserted
    rst = 1'b1;
    clear_all();
    for (int b = 0; b < NB; b++) begin
      set_wr(b, 1'b1, 1, 8'h11);
      set_rd(b, 1'b1, 2);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ready", 64'({o_wr_ready, o_rd_ready}), 64'(0));
      chk("rst_en", 64'({o_sram_a_wr_en, o_sram_b_rd_en}), 64'(0));
      chk("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
      tick();
    end

    // Banks 0 and 1 contend continuously: writes win 3 cycles, read on the 4th
    rst = 1'b0;
    clear_all();
    set_wr(0, 1'b1, 'h10, 'h11); set_rd(0, 1'b1, 'h20);
    set_wr(1, 1'b1, 'h30, 'h31); set_rd(1, 1'b1, 'h40);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("starve_wr c%0d", c), 64'({o_wr_ready[1], o_wr_ready[0]}), (c == 3) ? 64'(0) : 64'(3));
      chk($sformatf("starve_rd c%0d", c), 64'({o_rd_ready[1], o_rd_ready[0]}), (c == 3) ? 64'(3) : 64'(0));
      chk($sformatf("starve_rsp c%0d", c), 64'(o_rsp_valid[1]), 64'(c == 4));
      tick();
      if (c == 3) begin
        set_rd(0, 1'b0, 0);
        set_rd(1, 1'b0, 0);
      end
    end

    // Bank 2: write 0xA5 to 0x05, read it back next cycle
    clear_all();
    set_wr(2, 1'b1, 'h05, 'hA5);
    @(negedge clk);
    chk("b2_wr_ready", 64'(o_wr_ready[2]), 64'(1));
    chk("b2_wr_addr", 64'(o_sram_a_wr_addr[2*AW +: AW]), 64'h005);
    chk("b2_wr_data", 64'(o_sram_a_wr_data[2*DW +: DW]), 64'hA5);
    tick();
    clear_all();
    set_rd(2, 1'b1, 'h05);
    @(negedge clk);
    chk("b2_rd_ready", 64'({o_rd_ready[2], o_sram_a_wr_en[2]}), 64'b10);
    chk("b2_rd_addr", 64'(o_sram_b_rd_addr[2*AW +: AW]), 64'h005);
    tick();
    clear_all();
    @(negedge clk);
    chk("b2_rsp_valid", 64'(o_rsp_valid[2]), 64'(1));
    chk("b2_rsp_data", 64'(o_rsp_data[2*DW +: DW]), 64'hA5);
    tick();

    // Independence: bank 0 writes only, bank 3 reads only, every cycle
    for (int c = 0; c < 6; c++) begin
      set_wr(0, 1'b1, c, 'h30 + c);
      set_rd(3, 1'b1, c);
      @(negedge clk);
      chk($sformatf("indep_grant c%0d", c), 64'({o_wr_ready[0], o_rd_ready[3], o_rd_ready[0], o_wr_ready[3]}), 64'b1100);
      chk($sformatf("indep_rsp c%0d", c), 64'(o_rsp_valid[3]), 64'(c > 0));
      tick();
    end
    clear_all();
    tick();

    // Reset mid-read on bank 0 while bank 1 has accumulated lost cycles
    set_wr(1, 1'b1, 'h50, 'h5A); set_rd(1, 1'b1, 'h51);
    tick();
    set_rd(0, 1'b1, 'h10);
    @(negedge clk);
    chk("mid_rd_grant", 64'({o_rd_ready[0], o_wr_ready[1]}), 64'b11);
    tick();
    rst = 1'b1;
    set_rd(0, 1'b0, 0);
    @(negedge clk);
    chk("mid_rst_rsp", 64'(o_rsp_valid[0]), 64'(0));
    chk("mid_rst_ready", 64'({o_wr_ready, o_rd_ready}), 64'(0));
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_cnt c%0d", c), 64'({o_wr_ready[1], o_rd_ready[1]}), (c == 3) ? 64'b01 : 64'b10);
      chk($sformatf("post_rst_rsp c%0d", c), 64'(o_rsp_valid[0]), 64'(0));
      tick();
    end
    clear_all();
    tick();

    // Random traffic: requesters hold each request until it is granted
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      wg = o_wr_ready;
      rg = o_rd_ready;
      tick();
      for (int b = 0; b < NB; b++) begin
        rd_keep = i_rd_valid[b] && !rg[b];
        wr_keep = i_wr_valid[b] && !wg[b];
        if (!wr_keep) begin
          nv = ($urandom_range(99) < 70);
          do a = int'($urandom_range(7)); while (rd_keep && AW'(a) == i_rd_addr[b*AW +: AW]);
          set_wr(b, nv, a, int'($urandom_range(255)));
        end
        if (!rd_keep) begin
          nv = ($urandom_range(99) < 60);
          do a = int'($urandom_range(7)); while (i_wr_valid[b] && AW'(a) == i_wr_addr[b*AW +: AW]);
          set_rd(b, nv, a);
        end
      end
    end
    clear_all();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
